loopback_mc: RTL
================

# loopback_mc

Multi-lane, single-clock loopback BER tester; parametrised successor to the single-lane loopback checker in the DragonPHY top-level bench. Per lane, it compares recovered RX bits against a delayed copy of the TX stimulus, e.g. PRBS from `prbs21`. It searches each lane's TX-to-RX latency autonomously, locks, then accumulates correct/total bit counts. A lane-select readout port serves VIO/JTAG.

## Interface
Parameters:
- `N_LANES`, 4: number of independent lanes.
- `MAX_LAT`, 64: latency search depth in valid cycles; power of two, ≥2.
- `ALIGN_LEN`, 32: consecutive matches required to lock a lane.
- `CNT_W`, 64: width of the bit counters.

Ports (`LW = $clog2(MAX_LAT)`, `SW = max(1,$clog2(N_LANES))`):
- `clk_i` in 1: single clock; all inputs and outputs are synchronous to it.
- `rst_i` in 1: reset, synchronous, active-high.
- `valid_i` in 1: qualifies `data_tx_i` and `data_rx_i` for all lanes this cycle.
- `data_tx_i` in N_LANES: reference TX bit per lane.
- `data_rx_i` in N_LANES: recovered RX bit per lane.
- `mode_i` in 2: 0 CLEAR, 1 ALIGN, 2 TEST, 3 HOLD.
- `lane_sel_i` in SW: lane routed to the readout outputs.
- `locked_o` out N_LANES: per-lane lock flag.
- `all_locked_o` out 1: AND of `locked_o`.
- `latency_o` out LW: locked/candidate latency of the selected lane.
- `correct_bits_o` out CNT_W: correct-bit count of the selected lane.
- `total_bits_o` out CNT_W: total-bit count of the selected lane.

## Operation
- **History.** Each lane keeps a shift register of TX bits.
  - `hist[0]` is `data_tx_i` in the current cycle; `hist[k]` is the TX bit from k valid cycles earlier, for k ≤ MAX_LAT-1.
  - The register shifts only when `valid_i`=1.
- **Compare.** Per lane, `match = (data_rx_i == hist[L])`, where L is that lane's latency register.
- **Valid gating.** When `valid_i`=0, no per-lane state changes.
- **Per-lane state machine:**
  - UNLOCKED: L, run_cnt and the counters are cleared.
  - SEARCH: entered from UNLOCKED when `mode_i`=ALIGN. On each valid cycle:
    - match: run_cnt++. When run_cnt reaches ALIGN_LEN-1 on a match, go to LOCKED and keep L.
    - mismatch: run_cnt←0 and L←(L+1) mod MAX_LAT; wrap-around is silent and the search continues indefinitely.
  - LOCKED: L is frozen. ALIGN mode has no further effect.
- **TEST.** Lanes in LOCKED increment `total` by 1 and `correct` by `match` on each valid cycle.
  - SEARCH lanes keep searching in TEST.
  - UNLOCKED lanes remain idle in TEST.
- **Counters.** Saturating: at all-ones they hold, and `total` never wraps.
- **CLEAR.** On any clock with `mode_i`=0, every lane goes to UNLOCKED and all state is zeroed. This applies regardless of `valid_i`.
- **HOLD.** All state is frozen; the history still shifts.
- **Mode changes.** Take effect at the edge where the new `mode_i` is sampled. Data on that edge is processed under the new mode.

## Timing
- **Reset values.** `rst_i`=1 is identical to CLEAR. After it, all outputs are 0, including `all_locked_o`.
- **Readout latency.** `latency_o`, `correct_bits_o` and `total_bits_o` are registered muxes. They reflect `lane_sel_i` and state one cycle after sampling.
- **Locked flags.** `locked_o` and `all_locked_o` are registered from lane state and rise on the cycle after the locking edge.
- **Minimum lock time.** A lane whose true latency is L_true locks after at least ALIGN_LEN + L_true valid cycles, assuming matches thereafter.
- **Out-of-range selection.** `lane_sel_i` ≥ N_LANES reads as all-zero.

## Configuration
- `LOOPBACK_MC_ERRLOG_EN` defined:
  - Adds per-lane first-error capture.
  - Adds ports `err_seen_o` (out, N_LANES) and `first_err_o` (out, CNT_W). `first_err_o` is the selected lane's `total` value at its first mismatch in TEST, muxed like the other readouts.
  - Both are cleared by CLEAR/reset.
- Undefined: these ports and the capture logic are absent.

## Structure
- Package `loopback_mc_pkg`:
  - `mode_t` enum {CLEAR, ALIGN, TEST, HOLD}.
  - Lane state enum {UNLOCKED, SEARCH, LOCKED}.
- Sub-module `loopback_mc_lane`: history, state machine, counters and error log for one lane. The top instantiates it N_LANES times in a generate loop and adds the readout mux.

## Test plan
- **Reset/idle.** Reset, then `mode_i`=TEST with random data for 100 valid cycles → all outputs stay 0; no lane locks.
- **Latency search.** `data_rx_i[k]` = `data_tx_i[k]` delayed by {0,3,17,63} valid cycles, ALIGN for 200 cycles → `locked_o`=4'hF. Reading lanes 0..3 gives `latency_o` = 0, 3, 17, 63.
- **BER count.** Locked lane 1, TEST for 1000 valid cycles with RX bits inverted on exactly 7 of them → `total_bits_o`=1000, `correct_bits_o`=993.
- **Valid gating.** Toggle `valid_i` 50% while locked in TEST for 400 clocks → `total_bits_o`=200. HOLD for 100 clocks → counts are unchanged.
- **Saturation/clear.** With CNT_W=8, TEST for 300 valid cycles → `total_bits_o`=255. One CLEAR cycle → all zero and `locked_o`=0.
- **Error log.** `LOOPBACK_MC_ERRLOG_EN` defined, first mismatch at total=42 → `first_err_o`=42 and `err_seen_o[sel]`=1; later errors do not change them.

Source files
------------

// File: rtl/loopback_mc_pkg.sv
// loopback_mc_pkg: shared mode and lane-state encodings for the loopback BER tester
package loopback_mc_pkg;
  typedef enum logic [1:0] {CLEAR, ALIGN, TEST, HOLD} mode_t;
  typedef enum logic [1:0] {UNLOCKED, SEARCH, LOCKED} lane_state_t;
endpackage

// File: rtl/loopback_mc_lane.sv
// loopback_mc_lane: one lane's TX history, latency search, lock and saturating bit counters
// Optional first-error capture is built when LOOPBACK_MC_ERRLOG_EN is defined.
module loopback_mc_lane
  import loopback_mc_pkg::*;
#(
  parameter int MAX_LAT = 64,
  parameter int ALIGN_LEN = 32,
  parameter int CNT_W = 64,
  parameter int LW = $clog2(MAX_LAT)
) (
  input logic clk_i,
  input logic rst_i,
  input logic valid_i,
  input mode_t mode_i,
  input logic tx_i,
  input logic rx_i,
  output logic locked_o,
  output logic [LW-1:0] latency_o,
  output logic [CNT_W-1:0] correct_o,
  output logic [CNT_W-1:0] total_o
`ifdef LOOPBACK_MC_ERRLOG_EN
  ,
  output logic err_seen_o,
  output logic [CNT_W-1:0] first_err_o
`endif
);
  localparam int RW = $clog2(ALIGN_LEN + 1);
  lane_state_t state;
  logic [MAX_LAT-2:0] sr;
  logic [MAX_LAT-1:0] hist;
  logic [LW-1:0] lat;
  logic [RW-1:0] run;
  logic match, searching, counting;
  assign hist = {sr, tx_i};
  assign match = rx_i == hist[lat];
  assign searching = (state == SEARCH && (mode_i == ALIGN || mode_i == TEST)) ||
                     (state == UNLOCKED && mode_i == ALIGN);
  assign counting = state == LOCKED && mode_i == TEST;
  assign locked_o = state == LOCKED;
  assign latency_o = lat;
  // History shift, latency search and counting, all gated by valid; CLEAR zeroes everything
  always_ff @(posedge clk_i) begin
    if (rst_i || mode_i == CLEAR) begin
      sr <= '0;
      state <= UNLOCKED;
      lat <= '0;
      run <= '0;
      correct_o <= '0;
      total_o <= '0;
`ifdef LOOPBACK_MC_ERRLOG_EN
      err_seen_o <= 1'b0;
      first_err_o <= '0;
`endif
    end else if (valid_i) begin
      sr <= hist[MAX_LAT-2:0];
      if (searching) begin
        if (match) begin
          run <= run + RW'(1);
          state <= run == RW'(ALIGN_LEN - 1) ? LOCKED : SEARCH;
        end else begin
          run <= '0;
          lat <= lat + LW'(1);
          state <= SEARCH;
        end
      end
      if (counting) begin
        total_o <= &total_o ? total_o : total_o + CNT_W'(1);
        correct_o <= (&correct_o || !match) ? correct_o : correct_o + CNT_W'(1);
`ifdef LOOPBACK_MC_ERRLOG_EN
        if (!match && !err_seen_o) begin
          err_seen_o <= 1'b1;
          first_err_o <= total_o;
        end
`endif
      end
    end
  end
endmodule

// File: rtl/loopback_mc.sv
// loopback_mc: multi-lane loopback BER tester with per-lane latency search and lane-select readout
// Optional LOOPBACK_MC_ERRLOG_EN adds per-lane first-error capture (err_seen_o, first_err_o).
module loopback_mc
  import loopback_mc_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int MAX_LAT = 64,
  parameter int ALIGN_LEN = 32,
  parameter int CNT_W = 64,
  localparam int LW = $clog2(MAX_LAT),
  localparam int SW = N_LANES > 1 ? $clog2(N_LANES) : 1
) (
  input logic clk_i,
  input logic rst_i,
  input logic valid_i,
  input logic [N_LANES-1:0] data_tx_i,
  input logic [N_LANES-1:0] data_rx_i,
  input logic [1:0] mode_i,
  input logic [SW-1:0] lane_sel_i,
  output logic [N_LANES-1:0] locked_o,
  output logic all_locked_o,
  output logic [LW-1:0] latency_o,
  output logic [CNT_W-1:0] correct_bits_o,
  output logic [CNT_W-1:0] total_bits_o
`ifdef LOOPBACK_MC_ERRLOG_EN
  ,
  output logic [N_LANES-1:0] err_seen_o,
  output logic [CNT_W-1:0] first_err_o
`endif
);
  logic [LW-1:0] lat_a [N_LANES];
  logic [CNT_W-1:0] corr_a [N_LANES];
  logic [CNT_W-1:0] tot_a [N_LANES];
  logic sel_ok;
`ifdef LOOPBACK_MC_ERRLOG_EN
  logic [CNT_W-1:0] ferr_a [N_LANES];
`endif
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    loopback_mc_lane #(
      .MAX_LAT(MAX_LAT),
      .ALIGN_LEN(ALIGN_LEN),
      .CNT_W(CNT_W),
      .LW(LW)
    ) u_lane (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .valid_i(valid_i),
      .mode_i(mode_t'(mode_i)),
      .tx_i(data_tx_i[i]),
      .rx_i(data_rx_i[i]),
      .locked_o(locked_o[i]),
      .latency_o(lat_a[i]),
      .correct_o(corr_a[i]),
      .total_o(tot_a[i])
`ifdef LOOPBACK_MC_ERRLOG_EN
      ,
      .err_seen_o(err_seen_o[i]),
      .first_err_o(ferr_a[i])
`endif
    );
  end
  assign all_locked_o = &locked_o;
  assign sel_ok = {1'b0, lane_sel_i} < (SW + 1)'(N_LANES);
  // Registered readout mux; out-of-range lanes read as zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      latency_o <= '0;
      correct_bits_o <= '0;
      total_bits_o <= '0;
`ifdef LOOPBACK_MC_ERRLOG_EN
      first_err_o <= '0;
`endif
    end else begin
      latency_o <= sel_ok ? lat_a[lane_sel_i] : '0;
      correct_bits_o <= sel_ok ? corr_a[lane_sel_i] : '0;
      total_bits_o <= sel_ok ? tot_a[lane_sel_i] : '0;
`ifdef LOOPBACK_MC_ERRLOG_EN
      first_err_o <= sel_ok ? ferr_a[lane_sel_i] : '0;
`endif
    end
  end
endmodule
